grid_access_arbiter: RTL and testbench

//  Single owner of the single-port grid cell RAM (GRID_SIZE_X x GRID_SIZE_Y cells, 4-bit cell code).

---
 rtl/grid_access_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_grid_access_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_access_arbiter.sv
// grid_access_arbiter
//   Sole owner of the single-port grid cell RAM. It shares the RAM between the
//   display read port, the game write port and the game read port. It also
//   runs a clear sequencer that wipes every cell to NULL before a new game.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   clear_req/busy/done      start a wipe / wipe in progress / 1-cycle done pulse
//   disp_rd_*                display read: level request, registered valid/data
//   game_wr_*                game write: level request held until ack, x/y/data
//   game_rd_*                game read: level request held until ack, then valid/data
//   oob_err                  pulses alongside a grant whose address is off-grid
//   ram_*                    registered RAM control; ram_rdata has 1-cycle latency
module grid_access_arbiter #(
    parameter int GRID_SIZE_X = 32,
    parameter int GRID_SIZE_Y = 24,
    parameter int ADDR_W      = 10,
    parameter int MAX_WAIT    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              disp_rd_req,
    input  logic [ADDR_W-1:0] disp_rd_addr,
    output logic              disp_rd_valid,
    output logic [3:0]        disp_rd_data,
    input  logic              game_wr_req,
    input  logic [4:0]        game_wr_x,
    input  logic [4:0]        game_wr_y,
    input  logic [3:0]        game_wr_data,
    output logic              game_wr_ack,
    input  logic              game_rd_req,
    input  logic [4:0]        game_rd_x,
    input  logic [4:0]        game_rd_y,
    output logic              game_rd_ack,
    output logic              game_rd_valid,
    output logic [3:0]        game_rd_data,
    output logic              oob_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_wdata,
    input  logic [3:0]        ram_rdata
);

    localparam int                CELLS     = GRID_SIZE_X * GRID_SIZE_Y;
    localparam int                WCNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_SAT  = WCNT_W'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [WCNT_W-1:0] wait_cnt;

    // Read return pipeline: stage 0 lines up with the ram_en cycle, stage 1 with
    // the cycle ram_rdata is valid. zero_pipe marks reads answered without RAM.
    logic [1:0] disp_pipe, game_pipe, zero_pipe;

    // A port is masked during its own ack cycle so a held level is not re-granted.
    logic wr_pend, rd_pend;
    assign wr_pend = game_wr_req && !game_wr_ack;
    assign rd_pend = game_rd_req && !game_rd_ack;

    // Range checks are done at 32 bits so they stay meaningful for any grid size.
    logic [31:0]       wr_xw, wr_yw, rd_xw, rd_yw, disp_aw;
    logic              wr_oob, rd_oob, disp_oob;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    always_comb begin
        wr_xw    = 32'(game_wr_x);
        wr_yw    = 32'(game_wr_y);
        rd_xw    = 32'(game_rd_x);
        rd_yw    = 32'(game_rd_y);
        disp_aw  = 32'(disp_rd_addr);
        wr_oob   = (wr_xw >= 32'(GRID_SIZE_X)) || (wr_yw >= 32'(GRID_SIZE_Y));
        rd_oob   = (rd_xw >= 32'(GRID_SIZE_X)) || (rd_yw >= 32'(GRID_SIZE_Y));
        disp_oob = disp_aw >= 32'(CELLS);
        wr_addr  = ADDR_W'(wr_yw * 32'(GRID_SIZE_X) + wr_xw);
        rd_addr  = ADDR_W'(rd_yw * 32'(GRID_SIZE_X) + rd_xw);
    end

    // One grant per cycle. A saturated wait counter hands the slot to the game
    // port ahead of the display; otherwise display > write > read.
    logic arb_ok, override, grant_disp, grant_wr, grant_rd;

    always_comb begin
        arb_ok     = (state == IDLE) && !clear_req;
        override   = (wait_cnt == WAIT_SAT);
        grant_disp = 1'b0;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        if (arb_ok) begin
            if (override && wr_pend)      grant_wr   = 1'b1;
            else if (override && rd_pend) grant_rd   = 1'b1;
            else if (disp_rd_req)         grant_disp = 1'b1;
            else if (wr_pend)             grant_wr   = 1'b1;
            else if (rd_pend)             grant_rd   = 1'b1;
        end
    end

    // Display reads that cannot reach the RAM (during a wipe, in the cycle a wipe
    // starts, or off-grid) still return on time, with data 0.
    logic disp_nomem, disp_take, game_take, zero_take;

    always_comb begin
        disp_nomem = disp_rd_req && ((state == CLEAR) || clear_req);
        disp_take  = grant_disp || disp_nomem;
        game_take  = grant_rd;
        zero_take  = disp_nomem || (grant_disp && disp_oob) || (grant_rd && rd_oob);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            disp_pipe     <= '0;
            game_pipe     <= '0;
            zero_pipe     <= '0;
            clear_busy    <= 1'b0;
            clear_done    <= 1'b0;
            disp_rd_valid <= 1'b0;
            disp_rd_data  <= '0;
            game_wr_ack   <= 1'b0;
            game_rd_ack   <= 1'b0;
            game_rd_valid <= 1'b0;
            game_rd_data  <= '0;
            oob_err       <= 1'b0;
            ram_en        <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
        end else begin
            game_wr_ack <= 1'b0;
            game_rd_ack <= 1'b0;
            oob_err     <= 1'b0;
            clear_done  <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;

            disp_pipe <= {disp_pipe[0], disp_take};
            game_pipe <= {game_pipe[0], game_take};
            zero_pipe <= {zero_pipe[0], zero_take};

            disp_rd_valid <= disp_pipe[1];
            game_rd_valid <= game_pipe[1];
            disp_rd_data  <= (disp_pipe[1] && !zero_pipe[1]) ? ram_rdata : 4'd0;
            game_rd_data  <= (game_pipe[1] && !zero_pipe[1]) ? ram_rdata : 4'd0;

            if (grant_wr || grant_rd)
                wait_cnt <= '0;
            else if ((state == IDLE) && (wr_pend || rd_pend) && (wait_cnt != WAIT_SAT))
                wait_cnt <= wait_cnt + WCNT_W'(1);

            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                        ram_en     <= 1'b1;
                        ram_we     <= 1'b1;
                        ram_addr   <= '0;
                    end else if (grant_disp) begin
                        if (disp_oob) begin
                            oob_err <= 1'b1;
                        end else begin
                            ram_en   <= 1'b1;
                            ram_addr <= disp_rd_addr;
                        end
                    end else if (grant_wr) begin
                        game_wr_ack <= 1'b1;
                        if (wr_oob) begin
                            oob_err <= 1'b1;
                        end else begin
                            ram_en    <= 1'b1;
                            ram_we    <= 1'b1;
                            ram_addr  <= wr_addr;
                            ram_wdata <= game_wr_data;
                        end
                    end else if (grant_rd) begin
                        game_rd_ack <= 1'b1;
                        if (rd_oob) begin
                            oob_err <= 1'b1;
                        end else begin
                            ram_en   <= 1'b1;
                            ram_addr <= rd_addr;
                        end
                    end
                end
                CLEAR: begin
                    // ram_addr doubles as the wipe pointer; it holds the cell
                    // being written in this cycle.
                    if (ram_addr == LAST_ADDR) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        ram_en   <= 1'b1;
                        ram_we   <= 1'b1;
                        ram_addr <= ram_addr + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_access_arbiter.sv
module tb_grid_access_arbiter;

    localparam int GX = 32, GY = 24, AW = 10, MW = 8, CELLS = GX * GY;
    localparam int NRAND = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_req, clear_busy, clear_done;
    logic          disp_rd_req, disp_rd_valid;
    logic [AW-1:0] disp_rd_addr;
    logic [3:0]    disp_rd_data;
    logic          game_wr_req, game_wr_ack;
    logic [4:0]    game_wr_x, game_wr_y;
    logic [3:0]    game_wr_data;
    logic          game_rd_req, game_rd_ack, game_rd_valid;
    logic [4:0]    game_rd_x, game_rd_y;
    logic [3:0]    game_rd_data;
    logic          oob_err, ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_wdata;
    logic [3:0]    ram_rdata = 4'd0;

    always #5 clk = ~clk;

    grid_access_arbiter #(.GRID_SIZE_X(GX), .GRID_SIZE_Y(GY), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
        .disp_rd_req(disp_rd_req), .disp_rd_addr(disp_rd_addr),
        .disp_rd_valid(disp_rd_valid), .disp_rd_data(disp_rd_data),
        .game_wr_req(game_wr_req), .game_wr_x(game_wr_x), .game_wr_y(game_wr_y),
        .game_wr_data(game_wr_data), .game_wr_ack(game_wr_ack),
        .game_rd_req(game_rd_req), .game_rd_x(game_rd_x), .game_rd_y(game_rd_y),
        .game_rd_ack(game_rd_ack), .game_rd_valid(game_rd_valid), .game_rd_data(game_rd_data),
        .oob_err(oob_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Single-port RAM with one cycle of read latency.
    logic [3:0] mem [CELLS];
    always @(posedge clk)
        if (ram_en && (ram_addr < AW'(CELLS))) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end

    typedef struct packed {
        logic en; logic we; logic [AW-1:0] addr; logic [3:0] wd;
        logic wack; logic rack; logic oob;
        logic dv; logic [3:0] dd; logic gv; logic [3:0] gd;
        logic busy; logic done;
    } out_t;

    typedef struct {
        logic dreq; logic [AW-1:0] daddr;
        logic wreq; logic [4:0] wx; logic [4:0] wy; logic [3:0] wd;
        logic rreq; logic [4:0] rx; logic [4:0] ry;
        out_t e;
    } vec_t;

    typedef struct { int due; bit disp; logic [3:0] data; } rd_t;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Don't-care fields are zeroed so only meaningful outputs are compared.
    function automatic out_t sample();
        out_t o;
        o.en = ram_en; o.we = ram_we;
        o.addr = ram_en ? ram_addr : '0;
        o.wd = ram_we ? ram_wdata : '0;
        o.wack = game_wr_ack; o.rack = game_rd_ack; o.oob = oob_err;
        o.dv = disp_rd_valid; o.dd = disp_rd_valid ? disp_rd_data : '0;
        o.gv = game_rd_valid; o.gd = game_rd_valid ? game_rd_data : '0;
        o.busy = clear_busy; o.done = clear_done;
        return o;
    endfunction

    function automatic logic [63:0] raw_outs();
        return 64'({clear_busy, clear_done, disp_rd_valid, disp_rd_data, game_wr_ack, game_rd_ack,
                    game_rd_valid, game_rd_data, oob_err, ram_en, ram_we, ram_addr, ram_wdata});
    endfunction

    function automatic out_t mo(bit en, bit we, int addr, int wd, bit wack, bit rack, bit oob,
                                bit dv, int dd, bit gv, int gd);
        out_t o;
        o = '0;
        o.en = en; o.we = we; o.addr = AW'(addr); o.wd = 4'(wd);
        o.wack = wack; o.rack = rack; o.oob = oob;
        o.dv = dv; o.dd = 4'(dd); o.gv = gv; o.gd = 4'(gd);
        return o;
    endfunction

    function automatic vec_t mv(bit dreq, int daddr, bit wreq, int wx, int wy, int wd,
                                bit rreq, int rx, int ry, out_t e);
        vec_t v;
        v.dreq = dreq; v.daddr = AW'(daddr);
        v.wreq = wreq; v.wx = 5'(wx); v.wy = 5'(wy); v.wd = 4'(wd);
        v.rreq = rreq; v.rx = 5'(rx); v.ry = 5'(ry);
        v.e = e;
        return v;
    endfunction

    // Reference model: transaction view of the grid and of pending read returns.
    bit         clr_on;
    int         clr_idx, wait_m;
    logic [3:0] grid [CELLS];
    rd_t        rq[$];
    out_t       exp_cur, exp_nxt;

    task automatic model_step(input int d);
        out_t o;
        bit   wr_p, rd_p, gpend;
        int   who, a;
        o = '0;
        wr_p  = game_wr_req && !exp_cur.wack;
        rd_p  = game_rd_req && !exp_cur.rack;
        gpend = wr_p || rd_p;
        if (rq.size() > 0 && rq[0].due == d) begin
            if (rq[0].disp) begin o.dv = 1; o.dd = rq[0].data; end
            else            begin o.gv = 1; o.gd = rq[0].data; end
            void'(rq.pop_front());
        end
        if (clr_on) begin
            if (clr_idx < CELLS) begin
                o.en = 1; o.we = 1; o.addr = AW'(clr_idx); o.busy = 1; clr_idx++;
            end else begin
                o.done = 1; clr_on = 0;
            end
            if (disp_rd_req) rq.push_back('{due: d + 2, disp: 1, data: 4'd0});
        end else if (clear_req) begin
            clr_on = 1; clr_idx = 1;
            o.en = 1; o.we = 1; o.addr = '0; o.busy = 1;
            for (int i = 0; i < CELLS; i++) grid[i] = 4'd0;
            if (disp_rd_req) rq.push_back('{due: d + 2, disp: 1, data: 4'd0});
            if (gpend && wait_m < MW) wait_m++;
        end else begin
            if (wait_m == MW && gpend) who = wr_p ? 2 : 3;
            else if (disp_rd_req)      who = 1;
            else if (wr_p)             who = 2;
            else if (rd_p)             who = 3;
            else                       who = 0;
            if (who >= 2) wait_m = 0;
            else if (gpend && wait_m < MW) wait_m++;
            case (who)
                1: begin
                    a = int'(disp_rd_addr);
                    if (a >= CELLS) begin
                        o.oob = 1; rq.push_back('{due: d + 2, disp: 1, data: 4'd0});
                    end else begin
                        o.en = 1; o.addr = AW'(a); rq.push_back('{due: d + 2, disp: 1, data: grid[a]});
                    end
                end
                2: begin
                    o.wack = 1;
                    if (int'(game_wr_x) >= GX || int'(game_wr_y) >= GY) o.oob = 1;
                    else begin
                        a = int'(game_wr_y) * GX + int'(game_wr_x);
                        o.en = 1; o.we = 1; o.addr = AW'(a); o.wd = game_wr_data; grid[a] = game_wr_data;
                    end
                end
                3: begin
                    o.rack = 1;
                    if (int'(game_rd_x) >= GX || int'(game_rd_y) >= GY) begin
                        o.oob = 1; rq.push_back('{due: d + 2, disp: 0, data: 4'd0});
                    end else begin
                        a = int'(game_rd_y) * GX + int'(game_rd_x);
                        o.en = 1; o.addr = AW'(a); rq.push_back('{due: d + 2, disp: 0, data: grid[a]});
                    end
                end
                default: ;
            endcase
        end
        exp_nxt = o;
    endtask

    vec_t tbl [21];
    int   bad, ack_at, disp_cnt;
    out_t ack_o;
    logic [3:0] codes [4];

    initial begin
        codes[0] = 4'd0; codes[1] = 4'd1; codes[2] = 4'd2; codes[3] = 4'd4;
        for (int i = 0; i < CELLS; i++) mem[i] = 4'd0;

        tbl[0]  = mv(0,   0, 1,  5,  3, 4, 0,  0,  0, mo(1,1,101,4, 1,0,0, 0,0, 0,0));
        tbl[1]  = mv(0,   0, 0,  0,  0, 0, 0,  0,  0, mo(0,0,  0,0, 0,0,0, 0,0, 0,0));
        tbl[2]  = mv(0,   0, 0,  0,  0, 0, 1,  5,  3, mo(1,0,101,0, 0,1,0, 0,0, 0,0));
        tbl[3]  = mv(0,   0, 0,  0,  0, 0, 0,  0,  0, mo(0,0,  0,0, 0,0,0, 0,0, 0,0));
        tbl[4]  = mv(0,   0, 0,  0,  0, 0, 0,  0,  0, mo(0,0,  0,0, 0,0,0, 0,0, 1,4));
        tbl[5]  = mv(1, 101, 1,  1,  0, 2, 1,  5,  3, mo(1,0,101,0, 0,0,0, 0,0, 0,0));
        tbl[6]  = mv(0,   0, 1,  1,  0, 2, 1,  5,  3, mo(1,1,  1,2, 1,0,0, 0,0, 0,0));
        tbl[7]  = mv(0,   0, 1,  1,  0, 2, 1,  5,  3, mo(1,0,101,0, 0,1,0, 1,4, 0,0));
        tbl[8]  = mv(0,   0, 0,  0,  0, 0, 1,  5,  3, mo(0,0,  0,0, 0,0,0, 0,0, 0,0));
        tbl[9]  = mv(0,   0, 0,  0,  0, 0, 0,  0,  0, mo(0,0,  0,0, 0,0,0, 0,0, 1,4));
        tbl[10] = mv(0,   0, 1,  0, 24, 1, 0,  0,  0, mo(0,0,  0,0, 1,0,1, 0,0, 0,0));
        tbl[11] = mv(0,   0, 0,  0,  0, 0, 1, 31, 31, mo(0,0,  0,0, 0,1,1, 0,0, 0,0));
        tbl[12] = mv(1, 768, 0,  0,  0, 0, 0,  0,  0, mo(0,0,  0,0, 0,0,1, 0,0, 0,0));
        tbl[13] = mv(1,   1, 0,  0,  0, 0, 0,  0,  0, mo(1,0,  1,0, 0,0,0, 0,0, 1,0));
        tbl[14] = mv(0,   0, 0,  0,  0, 0, 0,  0,  0, mo(0,0,  0,0, 0,0,0, 1,0, 0,0));
        tbl[15] = mv(0,   0, 0,  0,  0, 0, 0,  0,  0, mo(0,0,  0,0, 0,0,0, 1,2, 0,0));
        tbl[16] = mv(0,   0, 1, 31, 23, 4, 0,  0,  0, mo(1,1,767,4, 1,0,0, 0,0, 0,0));
        tbl[17] = mv(0,   0, 0,  0,  0, 0, 0,  0,  0, mo(0,0,  0,0, 0,0,0, 0,0, 0,0));
        tbl[18] = mv(0,   0, 0,  0,  0, 0, 1, 31, 23, mo(1,0,767,0, 0,1,0, 0,0, 0,0));
        tbl[19] = mv(0,   0, 0,  0,  0, 0, 0,  0,  0, mo(0,0,  0,0, 0,0,0, 0,0, 0,0));
        tbl[20] = mv(0,   0, 0,  0,  0, 0, 0,  0,  0, mo(0,0,  0,0, 0,0,0, 0,0, 1,4));

        rst = 1'b0; clear_req = 0; disp_rd_req = 0; disp_rd_addr = '0;
        game_wr_req = 0; game_wr_x = '0; game_wr_y = '0; game_wr_data = '0;
        game_rd_req = 0; game_rd_x = '0; game_rd_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", raw_outs(), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Full wipe; a second clear_req and a game write arrive mid-wipe.
        clear_req = 1; @(posedge clk); #1; clear_req = 0;
        bad = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (!(ram_en && ram_we && ram_addr == AW'(i) && ram_wdata == 4'd0 &&
                  clear_busy && !clear_done && !game_wr_ack)) bad++;
            if (i == 100) begin game_wr_req = 1; game_wr_x = 5'd2; game_wr_y = 5'd0; game_wr_data = 4'd1; end
            clear_req = (i == 300);
            @(posedge clk); #1;
        end
        clear_req = 0;
        chk("clear_seq", 64'(bad), 64'd0);
        chk("clear_done", 64'({clear_done, clear_busy, ram_en}), 64'b100);
        @(posedge clk); #1;
        chk("wr_after_clear", 64'({game_wr_ack, ram_en, ram_we, ram_addr}), 64'({3'b111, 10'd2}));
        game_wr_req = 0;
        @(posedge clk); #1;

        for (int r = 0; r < 21; r++) begin
            disp_rd_req = tbl[r].dreq; disp_rd_addr = tbl[r].daddr;
            game_wr_req = tbl[r].wreq; game_wr_x = tbl[r].wx; game_wr_y = tbl[r].wy; game_wr_data = tbl[r].wd;
            game_rd_req = tbl[r].rreq; game_rd_x = tbl[r].rx; game_rd_y = tbl[r].ry;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", r), 64'(sample()), 64'(tbl[r].e));
        end

        // Starvation override under continuous display traffic.
        disp_rd_req = 1; disp_rd_addr = 10'd101;
        game_wr_req = 1; game_wr_x = 5'd3; game_wr_y = 5'd0; game_wr_data = 4'd1;
        ack_at = -1; disp_cnt = 0; ack_o = '0;
        for (int i = 0; i < 20 && ack_at < 0; i++) begin
            @(posedge clk); #1;
            if (game_wr_ack) begin ack_at = i; ack_o = sample(); end
            else if (ram_en && !ram_we) disp_cnt++;
        end
        chk("override_cycle", 64'(ack_at), 64'd8);
        chk("override_disp_cnt", 64'(disp_cnt), 64'd8);
        chk("override_write", 64'({ack_o.en, ack_o.we, ack_o.addr}), 64'({2'b11, 10'd3}));
        game_wr_req = 0;
        @(posedge clk); #1;
        chk("disp_resume", 64'({ram_en, ram_we, ram_addr, game_wr_ack}), 64'({2'b10, 10'd101, 1'b0}));
        disp_rd_req = 0;
        repeat (4) @(posedge clk);
        #1;

        // Reset in the middle of a wipe with a display read in flight.
        clear_req = 1; @(posedge clk); #1; clear_req = 0;
        repeat (199) @(posedge clk);
        #1;
        chk("clr_addr199", 64'(ram_addr), 64'd199);
        disp_rd_req = 1; @(posedge clk); #1; disp_rd_req = 0;
        chk("clr_addr200", 64'(ram_addr), 64'd200);
        rst = 1'b0; #1;
        chk("reset_async", raw_outs(), 64'd0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (raw_outs() != 64'd0) bad++;
        end
        chk("post_reset_idle", 64'(bad), 64'd0);

        // Randomized traffic against the model; starts with a wipe so the grid is known.
        clr_on = 0; clr_idx = 0; wait_m = 0; exp_cur = '0;
        for (int i = 0; i < CELLS; i++) grid[i] = 4'd0;
        for (int c = 0; c < NRAND; c++) begin
            clear_req    = (c == 0) || ($urandom_range(0, 1499) == 0);
            disp_rd_req  = ($urandom_range(0, 2) == 0);
            disp_rd_addr = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(768, 1023))
                                                        : AW'($urandom_range(0, 767));
            if (!game_wr_req || game_wr_ack) begin
                game_wr_req  = ($urandom_range(0, 2) == 0);
                game_wr_x    = 5'($urandom_range(0, 31));
                game_wr_y    = 5'($urandom_range(0, 31));
                game_wr_data = codes[$urandom_range(0, 3)];
            end
            if (!game_rd_req || game_rd_ack) begin
                game_rd_req = ($urandom_range(0, 2) == 0);
                game_rd_x   = 5'($urandom_range(0, 31));
                game_rd_y   = 5'($urandom_range(0, 31));
            end
            model_step(c);
            @(posedge clk); #1;
            chk($sformatf("rand%0d", c), 64'(sample()), 64'(exp_nxt));
            exp_cur = exp_nxt;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
